// File: rtl/rvsteel_ram_arbiter.sv
// Two-manager arbiter in front of the single-port on-chip RAM.
// Define RVSTEEL_RAM_ARBITER_RR_EN for round-robin, else m0 has fixed priority.
module rvsteel_ram_arbiter (
  input  logic        clock,
  input  logic        reset,

  input  logic [31:0] m0_rw_address,
  output logic [31:0] m0_read_data,
  input  logic        m0_read_request,
  output logic        m0_read_response,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_strobe,
  input  logic        m0_write_request,
  output logic        m0_write_response,

  input  logic [31:0] m1_rw_address,
  output logic [31:0] m1_read_data,
  input  logic        m1_read_request,
  output logic        m1_read_response,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_strobe,
  input  logic        m1_write_request,
  output logic        m1_write_response,

  output logic [31:0] s_rw_address,
  input  logic [31:0] s_read_data,
  output logic        s_read_request,
  input  logic        s_read_response,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_write_strobe,
  output logic        s_write_request,
  input  logic        s_write_response
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   grant;
  logic   grant_next;
  logic   last_grant;
  logic   last_next;
  logic   req0;
  logic   req1;
  logic   tie_pick;

  assign req0 = m0_read_request | m0_write_request;
  assign req1 = m1_read_request | m1_write_request;

`ifdef RVSTEEL_RAM_ARBITER_RR_EN
  assign tie_pick = ~last_grant;
`else
  assign tie_pick = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last_grant;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_next = ISSUE;
          grant_next = (req0 & req1) ? tie_pick : req1;
          last_next  = grant_next;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (s_read_response | s_write_response)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_rw_address      = grant ? m1_rw_address : m0_rw_address;
    s_write_data      = grant ? m1_write_data : m0_write_data;
    s_write_strobe    = grant ? m1_write_strobe : m0_write_strobe;
    s_read_request    = 1'b0;
    s_write_request   = 1'b0;
    m0_read_response  = 1'b0;
    m0_write_response = 1'b0;
    m0_read_data      = 32'h0;
    m1_read_response  = 1'b0;
    m1_write_response = 1'b0;
    m1_read_data      = 32'h0;
    if (state == ISSUE) begin
      s_read_request  = grant ? m1_read_request : m0_read_request;
      s_write_request = grant ? m1_write_request : m0_write_request;
    end
    // Return path is combinational so the RAM's response adds no latency.
    if (state == WAIT) begin
      if (grant) begin
        m1_read_response  = s_read_response;
        m1_write_response = s_write_response;
        m1_read_data      = s_read_data;
      end else begin
        m0_read_response  = s_read_response;
        m0_write_response = s_write_response;
        m0_read_data      = s_read_data;
      end
    end
  end

endmodule

// File: tb/tb_rvsteel_ram_arbiter.sv
// Bench for rvsteel_ram_arbiter: RAM model with variable latency plus
// a transaction-level reference (grant order, memory contents).
module tb_rvsteel_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_rw_address, m0_read_data, m0_write_data;
  logic        m0_read_request, m0_read_response;
  logic        m0_write_request, m0_write_response;
  logic [3:0]  m0_write_strobe;
  logic [31:0] m1_rw_address, m1_read_data, m1_write_data;
  logic        m1_read_request, m1_read_response;
  logic        m1_write_request, m1_write_response;
  logic [3:0]  m1_write_strobe;
  logic [31:0] s_rw_address, s_read_data, s_write_data;
  logic        s_read_request, s_read_response;
  logic        s_write_request, s_write_response;
  logic [3:0]  s_write_strobe;

  rvsteel_ram_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_rw_address(m0_rw_address), .m0_read_data(m0_read_data),
    .m0_read_request(m0_read_request), .m0_read_response(m0_read_response),
    .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
    .m0_write_request(m0_write_request), .m0_write_response(m0_write_response),
    .m1_rw_address(m1_rw_address), .m1_read_data(m1_read_data),
    .m1_read_request(m1_read_request), .m1_read_response(m1_read_response),
    .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
    .m1_write_request(m1_write_request), .m1_write_response(m1_write_response),
    .s_rw_address(s_rw_address), .s_read_data(s_read_data),
    .s_read_request(s_read_request), .s_read_response(s_read_response),
    .s_write_data(s_write_data), .s_write_strobe(s_write_strobe),
    .s_write_request(s_write_request), .s_write_response(s_write_response)
  );

  always #5 clock = ~clock;

  int          nerr = 0;
  int          nchk = 0;
  int          ram_lat = 0;
  bit          inject = 1'b0;
  bit          ref_last = 1'b1;
  logic [31:0] ref_mem [0:63];

  logic [31:0] mem [0:63];
  bit          mem_init = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic        prd, pwr;
  logic [31:0] pa, pd;
  logic [3:0]  ps;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    if (i == 4) return 32'hDEADBEEF;
    w = 32'(i + 1) * 32'h9E3779B9;
    return w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    s_read_response  <= 1'b0;
    s_write_response <= 1'b0;
    s_read_data      <= $urandom;
    if (!reset) begin
      pend <= 1'b0;
      if (!mem_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        mem_init <= 1'b1;
      end
    end else if (inject) begin
      s_read_response <= 1'b1;
    end else if (pend) begin
      if (cnt == 0) begin
        pend <= 1'b0;
        if (prd) begin
          s_read_response <= 1'b1;
          s_read_data     <= mem[pa[7:2]];
        end
        if (pwr) begin
          s_write_response <= 1'b1;
          mem[pa[7:2]]     <= merge(mem[pa[7:2]], pd, ps);
        end
      end else begin
        cnt <= cnt - 1;
      end
    end else if (s_read_request | s_write_request) begin
      if (ram_lat == 0) begin
        if (s_read_request) begin
          s_read_response <= 1'b1;
          s_read_data     <= mem[s_rw_address[7:2]];
        end
        if (s_write_request) begin
          s_write_response <= 1'b1;
          mem[s_rw_address[7:2]] <=
            merge(mem[s_rw_address[7:2]], s_write_data, s_write_strobe);
        end
      end else begin
        pend <= 1'b1;
        cnt  <= ram_lat - 1;
        prd  <= s_read_request;
        pwr  <= s_write_request;
        pa   <= s_rw_address;
        pd   <= s_write_data;
        ps   <= s_write_strobe;
      end
    end
  end

  task automatic set_mgr(input int g, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    if (g == 0) begin
      m0_read_request = rd; m0_write_request = wr;
      m0_rw_address = a; m0_write_data = d; m0_write_strobe = s;
    end else begin
      m1_read_request = rd; m1_write_request = wr;
      m1_rw_address = a; m1_write_data = d; m1_write_strobe = s;
    end
  endtask

  task automatic idle_all();
    set_mgr(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_mgr(1, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic arbitrate(input bit r0, input bit r1, output int g);
    if (r0 && r1) begin
`ifdef RVSTEEL_RAM_ARBITER_RR_EN
      g = ref_last ? 0 : 1;
`else
      g = 0;
`endif
    end else begin
      g = r1 ? 1 : 0;
    end
    ref_last = g[0];
  endtask

  task automatic expect_txn(input string name, input int g,
                            input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] rdata);
    int n;
    bit done;
    logic [1:0]  gr, ot;
    logic [31:0] gr_d, ot_d;
    logic [5:0]  v;
    #1;
    v = {s_read_request, s_write_request, m0_read_response,
         m0_write_response, m1_read_response, m1_write_response};
    nchk++;
    if (v !== 6'b0) begin
      nerr++;
      $display("FAIL %s idle: got %b required 000000", name, v);
    end
    @(negedge clock);
    nchk++;
    if ({s_read_request, s_write_request} !== {rd, wr} || s_rw_address !== a) begin
      nerr++;
      $display("FAIL %s issue: req=%b addr=%h required req=%b addr=%h",
               name, {s_read_request, s_write_request}, s_rw_address, {rd, wr}, a);
    end
    if (wr) begin
      nchk++;
      if (s_write_data !== d || s_write_strobe !== s) begin
        nerr++;
        $display("FAIL %s wdata: got %h/%b required %h/%b",
                 name, s_write_data, s_write_strobe, d, s);
      end
    end
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (m0_read_response | m0_write_response |
          m1_read_response | m1_write_response) begin
        done = 1'b1;
      end else begin
        nchk++;
        if (s_read_request | s_write_request) begin
          nerr++;
          $display("FAIL %s wait_req: got %b required 00",
                   name, {s_read_request, s_write_request});
        end
        n++;
        if (n > 40) begin
          nerr++;
          $display("FAIL %s timeout: got no response required one", name);
          return;
        end
      end
    end
    nchk++;
    if (n != ram_lat) begin
      nerr++;
      $display("FAIL %s latency: got %0d required %0d", name, n, ram_lat);
    end
    gr   = g ? {m1_read_response, m1_write_response} : {m0_read_response, m0_write_response};
    ot   = g ? {m0_read_response, m0_write_response} : {m1_read_response, m1_write_response};
    gr_d = g ? m1_read_data : m0_read_data;
    ot_d = g ? m0_read_data : m1_read_data;
    nchk++;
    if (gr !== {rd, wr} || ot !== 2'b00 || ot_d !== 32'h0) begin
      nerr++;
      $display("FAIL %s route: grant=%0d resp=%b other=%b/%h required %b other=00/0",
               name, g, gr, ot, ot_d, {rd, wr});
    end
    if (rd) begin
      nchk++;
      if (gr_d !== rdata) begin
        nerr++;
        $display("FAIL %s rdata: got %h required %h", name, gr_d, rdata);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] v;
    reset = 1'b0;
    set_mgr(0, 1, 0, 32'h10, 32'h0, 4'h0);
    set_mgr(1, 1, 0, 32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      v = {s_read_request, s_write_request, m0_read_response,
           m0_write_response, m1_read_response, m1_write_response};
      nchk++;
      if (v !== 6'b0 || m0_read_data !== 32'h0 || m1_read_data !== 32'h0) begin
        nerr++;
        $display("FAIL reset cyc%0d: got %b %h %h required 000000 0 0",
                 i, v, m0_read_data, m1_read_data);
      end
    end
    idle_all();
    ref_last = 1'b1;
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    int g;
    @(negedge clock);
    ram_lat = 0;
    set_mgr(0, 1, 0, 32'h10, 32'h0, 4'h0);
    arbitrate(1, 0, g);
    expect_txn("m0_read", g, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
    idle_all();
  endtask

  task automatic test_write_read();
    int g;
    @(negedge clock);
    set_mgr(1, 0, 1, 32'h20, 32'h12345678, 4'b0011);
    arbitrate(0, 1, g);
    expect_txn("m1_write", g, 0, 1, 32'h20, 32'h12345678, 4'b0011, 32'h0);
    ref_mem[8] = merge(ref_mem[8], 32'h12345678, 4'b0011);
    idle_all();
    @(negedge clock);
    set_mgr(0, 1, 0, 32'h20, 32'h0, 4'h0);
    arbitrate(1, 0, g);
    expect_txn("m0_readback", g, 1, 0, 32'h20, 32'h0, 4'h0, ref_mem[8]);
    idle_all();
  endtask

  task automatic test_arbitration();
    int g;
    @(negedge clock);
    set_mgr(0, 1, 0, 32'h10, 32'h0, 4'h0);
    set_mgr(1, 1, 0, 32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
`ifdef RVSTEEL_RAM_ARBITER_RR_EN
      g = i % 2;
`else
      g = 0;
`endif
      ref_last = g[0];
      expect_txn($sformatf("arb%0d", i), g, 1, 0, g ? 32'h20 : 32'h10,
                 32'h0, 4'h0, g ? ref_mem[8] : ref_mem[4]);
      if (i < 3) @(negedge clock);
    end
    idle_all();
  endtask

  task automatic test_idle_inject();
    int g;
    @(negedge clock);
    inject = 1'b1;
    @(negedge clock);
    inject = 1'b0;
    nchk++;
    if ({m0_read_response, m0_write_response, m1_read_response,
         m1_write_response} !== 4'b0 || m0_read_data !== 32'h0 ||
        m1_read_data !== 32'h0) begin
      nerr++;
      $display("FAIL idle_inject: got resp %b data %h/%h required 0000 0/0",
               {m0_read_response, m0_write_response, m1_read_response,
                m1_write_response}, m0_read_data, m1_read_data);
    end
    @(negedge clock);
    set_mgr(0, 1, 0, 32'h10, 32'h0, 4'h0);
    arbitrate(1, 0, g);
    expect_txn("after_inject", g, 1, 0, 32'h10, 32'h0, 4'h0, ref_mem[4]);
    idle_all();
  endtask

  task automatic test_reset_mid_wait();
    int g;
    bit seen;
    @(negedge clock);
    ram_lat = 5;
    set_mgr(1, 0, 1, 32'h24, 32'hCAFEF00D, 4'hF);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle_all();
    @(negedge clock);
    nchk++;
    if ({s_read_request, s_write_request, m1_write_response} !== 3'b0) begin
      nerr++;
      $display("FAIL midreset: got %b required 000",
               {s_read_request, s_write_request, m1_write_response});
    end
    reset = 1'b1;
    ref_last = 1'b1;
    ram_lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (m1_write_response | s_read_request | s_write_request) seen = 1'b1;
    end
    nchk++;
    if (seen) begin
      nerr++;
      $display("FAIL abandoned: got activity required none");
    end
    set_mgr(0, 1, 0, 32'h10, 32'h0, 4'h0);
    set_mgr(1, 1, 0, 32'h24, 32'h0, 4'h0);
    arbitrate(1, 1, g);
    expect_txn("post_reset_tie", g, 1, 0, g ? 32'h24 : 32'h10, 32'h0, 4'h0,
               g ? ref_mem[9] : ref_mem[4]);
    idle_all();
  endtask

  task automatic test_random();
    bit          act [2];
    bit          ard [2];
    logic [31:0] aad [2];
    logic [31:0] adt [2];
    logic [3:0]  ast [2];
    int          g;
    int          m;
    act[0] = 1'b0;
    act[1] = 1'b0;
    @(negedge clock);
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 2; k++) begin
        if (!act[k] && $urandom_range(0, 1) == 1) begin
          act[k] = 1'b1;
          ard[k] = $urandom_range(0, 1) == 1;
          aad[k] = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
          adt[k] = $urandom;
          ast[k] = 4'($urandom_range(1, 15));
        end
      end
      if (!act[0] && !act[1]) begin
        m = $urandom_range(0, 1);
        act[m] = 1'b1;
        ard[m] = 1'b1;
        aad[m] = {24'h0, 4'($urandom_range(0, 15)), 2'b00};
        adt[m] = 32'h0;
        ast[m] = 4'h0;
      end
      for (int k = 0; k < 2; k++)
        set_mgr(k, act[k] & ard[k], act[k] & ~ard[k], aad[k], adt[k], ast[k]);
      ram_lat = $urandom_range(0, 3);
      arbitrate(act[0], act[1], g);
      expect_txn($sformatf("rand%0d", r), g, ard[g], ~ard[g], aad[g],
                 adt[g], ast[g], ref_mem[aad[g][7:2]]);
      if (!ard[g])
        ref_mem[aad[g][7:2]] = merge(ref_mem[aad[g][7:2]], adt[g], ast[g]);
      act[g] = 1'b0;
      set_mgr(g, 0, 0, 32'h0, 32'h0, 4'h0);
      @(negedge clock);
    end
    idle_all();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    idle_all();
    test_reset();
    test_single_read();
    test_write_read();
    test_arbitration();
    test_idle_inject();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rvsteel_ram_arbiter.md
# rvsteel_ram_arbiter

Two-manager arbiter placed directly upstream of the on-chip RAM. It accepts read/write transactions from the CPU (manager 0) and from a secondary manager such as a DMA engine or debug loader (manager 1), serialises them onto the RAM's single request/response port, and routes the RAM's response back to the manager that issued the request. At most one transaction is in flight at any time.

## Interface
Parameters:
- none.

Ports (N = 0, 1; one set per manager):
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising edge of clock; low = reset).
- mN_rw_address  input  32  manager N byte address.
- mN_read_data  output  32  read data to manager N.
- mN_read_request  input  1  manager N read request; held until mN_read_response.
- mN_read_response  output  1  one-cycle read completion to manager N.
- mN_write_data  input  32  manager N write data.
- mN_write_strobe  input  4  manager N byte enables.
- mN_write_request  input  1  manager N write request; held until mN_write_response.
- mN_write_response  output  1  one-cycle write completion to manager N.
- s_rw_address  output  32  address to RAM.
- s_read_data  input  32  read data from RAM.
- s_read_request  output  1  read request to RAM.
- s_read_response  input  1  read completion from RAM.
- s_write_data  output  32  write data to RAM.
- s_write_strobe  output  4  byte enables to RAM.
- s_write_request  output  1  write request to RAM.
- s_write_response  input  1  write completion from RAM.

## Operation
- State machine: IDLE, ISSUE, WAIT. Registers: state, grant (1 bit), last_grant (1 bit).
- IDLE: manager N is requesting if mN_read_request | mN_write_request. None -> stay IDLE. One -> grant it. Both -> arbitration rule (Configuration). Next state ISSUE; last_grant <= grant.
- ISSUE (exactly one cycle): s_rw_address, s_write_data, s_write_strobe, s_read_request, s_write_request driven from granted manager's inputs. Next state WAIT.
- WAIT: s_read_request = s_write_request = 0; s_rw_address/data/strobe stay muxed from granted manager. On s_read_response | s_write_response -> IDLE; otherwise stay (no timeout).
- Response routing (combinational): in WAIT, mG_read_response = s_read_response, mG_write_response = s_write_response, mG_read_data = s_read_data for granted G. Non-granted manager: responses 0, read_data 32'h0. In IDLE/ISSUE all manager responses 0, read_data 32'h0.
- s_* responses arriving in IDLE or ISSUE are ignored.
- Manager asserting both read and write: both forwarded; transaction ends on the first response of either kind; both responses routed if simultaneous. Illegal use, no further protection.
- Requests are not registered; a manager that drops its request before response still completes the issued transaction (response pulse delivered).

## Timing
- Reset (reset low at an edge): state IDLE, grant 0, last_grant 1; all s_* requests 0, all manager responses 0, all read_data 32'h0. Reset mid-ISSUE/WAIT abandons the transaction; no response delivered.
- With single-cycle RAM: request seen in IDLE at cycle 0; s_*_request high in cycle 1; RAM response in cycle 2 delivered to manager in cycle 2 (zero added latency on return path); IDLE in cycle 3.
- Throughput: one transaction per 3 cycles; back-to-back from the same manager permitted, new request must be asserted in cycle 3.
- s_rw_address during IDLE: muxed from grant (don't-care for RAM, request low).

## Configuration
- RVSTEEL_RAM_ARBITER_RR_EN defined: round-robin; on simultaneous requests in IDLE grant the manager not equal to last_grant.
- Not defined: fixed priority; manager 0 always wins simultaneous requests; last_grant still maintained but unused.

## Test plan
- Reset held low 3 cycles with both managers requesting -> no s_*_request, all responses 0, read_data 32'h0.
- m0 read of 0x0000_0010 (RAM word 0xDEAD_BEEF) alone -> s_read_request high exactly cycle 1, m0_read_response + m0_read_data 0xDEADBEEF in cycle 2, m1 sees nothing.
- m1 write 0x1234_5678 strobe 4'b0011 to 0x20, then m0 read 0x20 -> RAM word lower half 0x5678, m0_read_data reflects it.
- Both managers hold read requests continuously for 4 transactions -> with RR_EN grants m0,m1,m0,m1; without it m0,m0,m0,m0.
- Reset pulsed low during WAIT of m1 write -> no m1_write_response, state IDLE, next simultaneous request granted to m0.
- s_read_response injected in IDLE -> no manager response.
